mem_wait_responder: RTL and testbench
=====================================

// Module: mem_wait_responder
// PURPOSE
//  - Word-organised data memory that acts as the responder on a req/ack memory bus.
//  - Sits on the bus side of the multicycle CPU. It lets the control FSM be exercised
//    against a variable-latency memory instead of the fixed one-cycle Memoria.
//  - Accepts one read or write per handshake.
//  - Inserts WAIT_CYCLES of latency before answering.
//  - Flags out-of-range accesses.
// PARAMETERS
//  ADDR_W       8   word-index bits; array holds 2**ADDR_W x 32-bit words
//  WAIT_CYCLES  2   idle cycles between request capture and ack (0..15)
// PORTS
//  clock  in   1   single clock, all state updates on posedge
//  reset  in   1   synchronous, active-high
//  req    in   1   initiator request; held high until ack seen
//  wr     in   1   1 = write, 0 = read; sampled with req
//  addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  wdata  in   32  write data; sampled with req
//  ack    out  1   one-cycle pulse: transaction complete, rdata/err valid
//  rdata  out  32  read data; holds until next ack
//  busy   out  1   1 whenever FSM not in IDLE
//  err    out  1   pulses with ack on a rejected access
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - FSM to IDLE; ack=0, err=0, busy=0, rdata=0.
//    - All memory words cleared to 0.
//    - Any in-flight transaction is aborted: no write, no ack.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE, req=1:
//    - Latch wr, addr, wdata into internal regs; load wait counter with WAIT_CYCLES.
//    - Next state WAIT, or RESP directly if WAIT_CYCLES==0.
//  - IDLE, req=0: stay in IDLE.
//  - WAIT: decrement the counter each cycle; go to RESP on the edge where counter reaches 0.
//    req, wr, addr and wdata are ignored while in WAIT.
//  - Latency: the IDLE cycle that samples req is cycle 0. WAIT occupies cycles
//    1..WAIT_CYCLES. ack=1 in cycle WAIT_CYCLES+1 (RESP).
//  - Entering RESP (same edge that raises ack):
//    - Valid write: mem[idx] <= wdata; rdata unchanged.
//    - Valid read: rdata <= mem[idx].
//    - Rejected access: no write; rdata <= 0; err <= 1.
//  - RESP always returns to IDLE after exactly one cycle; ack and err drop there.
//  - Back-to-back: if req is still high in the IDLE cycle after RESP, a new transaction
//    starts. The initiator must drop req in the cycle after ack to avoid a repeat.
//    Minimum ack-to-ack spacing is WAIT_CYCLES+2 cycles.
//  - Range check: the access is rejected if addr[31:ADDR_W+2] != 0.
//  - Read-after-write to the same word returns the new data. The write has committed
//    before any later transaction.
//  - A write to word 0 is legal and is stored like any other word.
// CONFIGURATION
//  ERR_ON_MISALIGN_EN defined:
//    - An access with addr[1:0] != 0 is rejected: err=1, no write, rdata=0.
//  ERR_ON_MISALIGN_EN undefined:
//    - addr[1:0] is ignored and the access goes to the enclosing word.
//    - err reflects only the range check.
// TESTING (ADDR_W=8, WAIT_CYCLES=2 unless noted)
//  1. Hold reset 2 cycles, release -> ack=0, busy=0, err=0, rdata=0.
//     Then read 0x10 -> ack in cycle 3, rdata=0x00000000, err=0.
//  2. Write 0x40 / 0xDEADBEEF, drop req after ack, read 0x40 -> rdata=0xDEADBEEF.
//     Each ack arrives exactly 3 cycles after req is sampled.
//  3. Read 0x00000400 (word index 256, out of range) -> ack with err=1, rdata=0.
//     Then read 0x40 -> rdata=0xDEADBEEF (memory untouched).
//  4. Write 0x42 / 0x12345678:
//     - with ERR_ON_MISALIGN_EN: err=1; a later read of 0x40 returns the previous value.
//     - without it: err=0; a later read of 0x40 returns 0x12345678.
//  5. Write 0x20 / 0xCAFEF00D; assert reset for 1 cycle while in WAIT -> no ack, busy=0.
//     A later read of 0x20 returns 0.
//  6. Hold req=1, wr=0 across two transactions -> acks in cycles 3 and 7 (spacing 4),
//     each lasting 1 cycle. Repeat with WAIT_CYCLES=0 -> acks in cycles 1 and 3.

Source files
------------

// File: rtl/mem_wait_responder_if.sv
// ---------------------------------------------------------------------------
// mem_wait_responder_if
//   Request/acknowledge memory bus between an initiator (the multicycle CPU
//   control path) and a word-organised memory responder.
//
//   Signals
//     req    initiator request, held high until ack is seen
//     wr     1 = write, 0 = read, sampled with req
//     addr   32-bit byte address
//     wdata  32-bit write data, sampled with req
//     ack    one-cycle completion pulse from the responder
//     rdata  32-bit read data, holds until the next ack
//     busy   responder is not idle
//     err    pulses with ack when the access was rejected
//
//   Modports
//     master  initiator side (drives req/wr/addr/wdata)
//     slave   responder side (drives ack/rdata/busy/err)
// ---------------------------------------------------------------------------
interface mem_wait_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  modport master (
    output req, wr, addr, wdata,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, wr, addr, wdata,
    output ack, rdata, busy, err
  );
endinterface

// File: rtl/mem_wait_responder.sv
// ---------------------------------------------------------------------------
// mem_wait_responder
//   Word-organised data memory acting as the responder on a req/ack bus.
//   A request is captured in IDLE, held for WAIT_CYCLES cycles in WAIT and
//   answered with a one-cycle ack in RESP. Writes commit and reads load rdata
//   on the edge that enters RESP. Accesses above the array are rejected with
//   err, no write and rdata = 0.
//
//   Parameters
//     ADDR_W       word-index bits; array is 2**ADDR_W x 32-bit words
//     WAIT_CYCLES  cycles spent in WAIT between capture and ack (0..15)
//
//   Ports
//     clock  single clock, every state update on its rising edge
//     reset  synchronous, active-high; clears FSM, outputs and all memory
//            words and aborts any in-flight transaction
//     bus    mem_wait_responder_if.slave (req/wr/addr/wdata in,
//            ack/rdata/busy/err out)
//
//   Build option
//     ERR_ON_MISALIGN_EN  when defined, an access with addr[1:0] != 0 is also
//                         rejected; when undefined the byte offset is ignored
//                         and the access goes to the enclosing word.
// ---------------------------------------------------------------------------
module mem_wait_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clock,
  input logic                 reset,
  mem_wait_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [3:0]        waitCnt;

  // Request captured in IDLE; used while the FSM is in WAIT.
  logic              wrQ;
  logic [31:0]       addrQ;
  logic [31:0]       wdataQ;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdataQ;
  logic              errQ;

  // Effective request seen by the datapath on the edge that enters RESP.
  logic              curWr;
  logic [31:0]       curAddr;
  logic [31:0]       curWdata;
  logic [ADDR_W-1:0] wordIdx;
  logic              outOfRange;
  logic              misaligned;
  logic              reject;

  logic              capture;
  logic              enterResp;
  logic              ackC;
  logic              busyC;

  // -------------------------------------------------------------------------
  // Request selection and access checks
  // -------------------------------------------------------------------------
  // With WAIT_CYCLES == 0 the FSM goes IDLE -> RESP on the capture edge, so
  // the captured registers are not loaded yet; take the live bus values then.
  // From WAIT the captured copy is used, since bus inputs are ignored there.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    curWr    = wrQ;
    curAddr  = addrQ;
    curWdata = wdataQ;
    if (state == IDLE) begin
      curWr    = bus.wr;
      curAddr  = bus.addr;
      curWdata = bus.wdata;
    end
  end

  assign wordIdx    = curAddr[ADDR_W+1:2];
  assign outOfRange = |curAddr[31:ADDR_W+2];

`ifdef ERR_ON_MISALIGN_EN
  assign misaligned = |curAddr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign reject = outOfRange | misaligned;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    capture   = 1'b0;
    ackC      = 1'b0;
    busyC     = 1'b1;
    case (state)
      IDLE: begin
        busyC = 1'b0;
        if (bus.req) begin
          capture   = 1'b1;
          nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      // Counter holds the remaining WAIT cycles; leave on the edge where it
      // steps from 1 to 0.
      WAIT: begin
        if (waitCnt <= 4'd1) nextState = RESP;
      end
      RESP: begin
        ackC      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign enterResp = (nextState == RESP);

  // -------------------------------------------------------------------------
  // Request capture and wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wrQ     <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      waitCnt <= '0;
    end else if (capture) begin
      wrQ     <= bus.wr;
      addrQ   <= bus.addr;
      wdataQ  <= bus.wdata;
      waitCnt <= WAIT_LOAD;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt - 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Memory array
  // -------------------------------------------------------------------------
  // NOTE: the array is cleared on reset, so it is built from flops rather
  // than a RAM macro, which could not be reset word by word.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enterResp && curWr && !reject) begin
      mem[wordIdx] <= curWdata;
    end
  end

  // -------------------------------------------------------------------------
  // Response registers: loaded on the edge that enters RESP, so they are
  // valid together with ack. err drops as the FSM leaves RESP; rdata holds.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      errQ <= enterResp && reject;
      if (enterResp) begin
        if (reject)      rdataQ <= '0;
        else if (!curWr) rdataQ <= mem[wordIdx];
      end
    end
  end

  assign bus.ack   = ackC;
  assign bus.busy  = busyC;
  assign bus.rdata = rdataQ;
  assign bus.err   = errQ;

endmodule

// File: tb/tb_mem_wait_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_wait_responder
//   Directed bench for mem_wait_responder. dut0 uses ADDR_W=8, WAIT_CYCLES=2;
//   dut1 uses WAIT_CYCLES=0 for the zero-latency back-to-back case. Inputs
//   change and outputs are sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_mem_wait_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_wait_responder_if bus0 ();
  mem_wait_responder_if bus1 ();

  mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clock (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clock (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int          total = 0;
  int          bad   = 0;
  int          lat;
  logic [31:0] rd;
  logic        e;
  logic [8:0]  ackMask;
  logic        ackSeen;

`ifdef ERR_ON_MISALIGN_EN
  localparam logic [31:0] MISALIGN_ERR = 32'd1;
  localparam logic [31:0] AFTER_0X42   = 32'hDEADBEEF;
`else
  localparam logic [31:0] MISALIGN_ERR = 32'd0;
  localparam logic [31:0] AFTER_0X42   = 32'h12345678;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One transaction on dut0, starting at a falling edge. lat counts falling
  // edges until ack is seen (bounded); req drops in the ack cycle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus0.req   = 1'b1;
    bus0.wr    = w;
    bus0.addr  = a;
    bus0.wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus0.ack !== 1'b1 && lat < 20);
    rd       = bus0.rdata;
    e        = bus0.err;
    bus0.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.wdata = '0;

    // 1. reset state, then first read
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ack",   32'(bus0.ack),  32'd0);
    chk("rst_busy",  32'(bus0.busy), 32'd0);
    chk("rst_err",   32'(bus0.err),  32'd0);
    chk("rst_rdata", bus0.rdata,     32'd0);
    txn(1'b0, 32'h10, 32'h0);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_rd",  rd,       32'h0);
    chk("t1_err", 32'(e),   32'd0);

    // 2. write then read back; rdata untouched by the write
    txn(1'b1, 32'h40, 32'hDEADBEEF);
    chk("t2w_lat", 32'(lat), 32'd3);
    chk("t2w_rd",  rd,       32'h0);
    chk("t2w_err", 32'(e),   32'd0);
    chk("t2_idle_ack",  32'(bus0.ack),  32'd0);
    chk("t2_idle_busy", 32'(bus0.busy), 32'd0);
    txn(1'b0, 32'h40, 32'h0);
    chk("t2r_lat", 32'(lat), 32'd3);
    chk("t2r_rd",  rd,       32'hDEADBEEF);

    // 3. out-of-range read, then memory untouched
    txn(1'b0, 32'h400, 32'h0);
    chk("t3_lat", 32'(lat), 32'd3);
    chk("t3_err", 32'(e),   32'd1);
    chk("t3_rd",  rd,       32'h0);
    chk("t3_err_drop", 32'(bus0.err), 32'd0);
    txn(1'b1, 32'hFFFF_FFFC, 32'h55555555);
    chk("t3w_err", 32'(e), 32'd1);
    txn(1'b0, 32'h40, 32'h0);
    chk("t3r_rd",  rd,     32'hDEADBEEF);
    chk("t3r_err", 32'(e), 32'd0);

    // 4. misaligned write to 0x42
    txn(1'b1, 32'h42, 32'h12345678);
    chk("t4w_err", 32'(e), MISALIGN_ERR);
    txn(1'b0, 32'h40, 32'h0);
    chk("t4r_rd", rd, AFTER_0X42);

    // Boundary words: word 0 and the top word 255
    txn(1'b1, 32'h0, 32'hA5A5A5A5);
    txn(1'b1, 32'h3FC, 32'h0BADF00D);
    chk("top_w_err", 32'(e), 32'd0);
    txn(1'b0, 32'h0, 32'h0);
    chk("w0_rd", rd, 32'hA5A5A5A5);
    txn(1'b0, 32'h3FC, 32'h0);
    chk("top_rd", rd, 32'h0BADF00D);

    // 5. reset during WAIT aborts the write
    bus0.req = 1'b1; bus0.wr = 1'b1; bus0.addr = 32'h20; bus0.wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t5_busy_wait", 32'(bus0.busy), 32'd1);
    reset    = 1'b1;
    bus0.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_ack",   32'(bus0.ack),  32'd0);
    chk("t5_busy",  32'(bus0.busy), 32'd0);
    chk("t5_rdata", bus0.rdata,     32'd0);
    ackSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ackSeen = ackSeen | bus0.ack;
    end
    chk("t5_no_ack", 32'(ackSeen), 32'd0);
    txn(1'b0, 32'h20, 32'h0);
    chk("t5_rd20", rd, 32'h0);
    txn(1'b0, 32'h40, 32'h0);
    chk("t5_rd40", rd, 32'h0);

    // 6. req held across two reads: acks in cycles 3 and 7 (WAIT_CYCLES=2)
    bus0.req = 1'b1; bus0.wr = 1'b0; bus0.addr = 32'h40;
    ackMask = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ackMask[c] = bus0.ack;
    end
    bus0.req = 1'b0;
    chk("t6_mask_w2", 32'(ackMask), 32'h088);
    repeat (3) @(negedge clk);
    chk("t6_idle_w2", 32'(bus0.busy), 32'd0);

    //    and with WAIT_CYCLES=0: acks in cycles 1 and 3
    bus1.req = 1'b1; bus1.wr = 1'b0; bus1.addr = 32'h40;
    ackMask = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ackMask[c] = bus1.ack;
    end
    bus1.req = 1'b0;
    chk("t6_mask_w0", 32'(ackMask), 32'h00A);
    @(negedge clk);
    chk("t6_idle_w0", 32'(bus1.busy), 32'd0);

    // WAIT_CYCLES=0 write/read round trip
    bus1.req = 1'b1; bus1.wr = 1'b1; bus1.addr = 32'h8; bus1.wdata = 32'h13579BDF;
    @(negedge clk);
    chk("w0_wack", 32'(bus1.ack), 32'd1);
    bus1.req = 1'b0;
    @(negedge clk);
    bus1.req = 1'b1; bus1.wr = 1'b0;
    @(negedge clk);
    chk("w0_rack", 32'(bus1.ack), 32'd1);
    chk("w0_rdata", bus1.rdata, 32'h13579BDF);
    bus1.req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
